// File: rtl/dkong3_audio_pkg.sv
// Shared widths and arithmetic helpers for the dkong3 audio output conditioning stage.
package dkong3_audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned LP_W     = 24;
  localparam int unsigned HP_W     = 20;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [LP_W-1:0]     lp_t;
  typedef logic signed [HP_W-1:0]     hp_t;

  // One guard bit so the low-pass difference cannot overflow.
  function automatic logic signed [LP_W:0] sext_lp(input logic [LP_W-1:0] v);
    return {v[LP_W-1], v};
  endfunction

  function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'h7fff;
    end else if (v < -32'sd32768) begin
      return 16'h8000;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dkong3_dc_block.sv
// DC-blocking high-pass (hp) followed by gain, saturation and optional mute of each decimated sample.
module dkong3_dc_block
  import dkong3_audio_pkg::*;
#(
  parameter int unsigned DC_SHIFT   = 10,
  parameter int unsigned GAIN_SHIFT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] x_i,
  input  logic                stb_i,
  input  logic                mute_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                stb_o
);

  localparam logic signed [HP_W+1:0] HpMax = (HP_W+2)'((1 << (HP_W - 1)) - 1);
  localparam logic signed [HP_W+1:0] HpMin = -HpMax;

  hp_t                   hp_q, hp_d;
  logic [SAMPLE_W-1:0]   xprev_q;
  logic                  s2_vld_q;
  logic [SAMPLE_W-1:0]   sample_q;
  logic                  stb_q;
  logic signed [HP_W+1:0] x_ext, xp_ext, hp_ext, hp_sum;
  logic signed [31:0]    gained;

  always_comb begin
    x_ext  = {{(HP_W + 2 - SAMPLE_W){x_i[SAMPLE_W-1]}}, x_i};
    xp_ext = {{(HP_W + 2 - SAMPLE_W){xprev_q[SAMPLE_W-1]}}, xprev_q};
    hp_ext = {{2{hp_q[HP_W-1]}}, hp_q};
    hp_sum = x_ext - xp_ext + hp_ext - (hp_ext >>> DC_SHIFT);
    if (hp_sum > HpMax) begin
      hp_d = HpMax[HP_W-1:0];
    end else if (hp_sum < HpMin) begin
      hp_d = HpMin[HP_W-1:0];
    end else begin
      hp_d = hp_sum[HP_W-1:0];
    end
    gained = {{(32 - HP_W){hp_q[HP_W-1]}}, hp_q};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hp_q     <= '0;
      xprev_q  <= '0;
      s2_vld_q <= 1'b0;
      sample_q <= '0;
      stb_q    <= 1'b0;
    end else begin
      s2_vld_q <= stb_i;
      stb_q    <= s2_vld_q;
      if (stb_i) begin
        hp_q    <= hp_d;
        xprev_q <= x_i;
      end
      if (s2_vld_q) begin
        sample_q <= mute_i ? '0 : sat16(gained <<< GAIN_SHIFT);
      end
    end
  end

  assign sample_o = sample_q;
  assign stb_o    = stb_q;

endmodule

// File: rtl/dkong3_audio_out.sv
// Audio output stage: clock-rate anti-alias low-pass, fractional-N decimation strobe,
// then DC block, gain and saturation to a strobed 16-bit sample.
module dkong3_audio_out
  import dkong3_audio_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 24000000,
  parameter int unsigned OUT_HZ     = 48000,
  parameter int unsigned LP_SHIFT   = 6,
  parameter int unsigned DC_SHIFT   = 10,
  parameter int unsigned GAIN_SHIFT = 1
) (
  input  logic                I_SUBCLK,
  input  logic                I_RESET,
  input  logic [SAMPLE_W-1:0] I_SAMPLE,
  input  logic                I_MUTE,
  output logic [SAMPLE_W-1:0] O_SAMPLE,
  output logic                O_SAMPLE_STB
);

  // The three-stage pipeline must drain before the next tick.
  if (CLK_HZ < 4 * OUT_HZ) begin : g_bad_ratio
    $error("dkong3_audio_out: CLK_HZ must be at least 4*OUT_HZ");
  end
  if (GAIN_SHIFT > 3) begin : g_bad_gain
    $error("dkong3_audio_out: GAIN_SHIFT must be 0..3");
  end

  lp_t                   lp_q, lp_d;
  logic signed [LP_W:0]  lp_diff;
  logic [31:0]           acc_q, acc_d;
  logic [32:0]           acc_nxt;
  logic                  tick_q, tick_d;
  logic [SAMPLE_W-1:0]   x_q;
  logic                  x_vld_q;

  always_comb begin
    lp_diff = sext_lp({I_SAMPLE, 8'h00}) - sext_lp(lp_q);
    lp_d    = lp_q + lp_t'(lp_diff >>> LP_SHIFT);

    acc_nxt = {1'b0, acc_q} + 33'(OUT_HZ);
    if (acc_nxt >= 33'(CLK_HZ)) begin
      acc_d  = 32'(acc_nxt - 33'(CLK_HZ));
      tick_d = 1'b1;
    end else begin
      acc_d  = acc_nxt[31:0];
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge I_SUBCLK or posedge I_RESET) begin
    if (I_RESET) begin
      lp_q    <= '0;
      acc_q   <= '0;
      tick_q  <= 1'b0;
      x_q     <= '0;
      x_vld_q <= 1'b0;
    end else begin
      lp_q    <= lp_d;
      acc_q   <= acc_d;
      tick_q  <= tick_d;
      x_vld_q <= tick_q;
      if (tick_q) begin
        x_q <= lp_q[LP_W-1:LP_W-SAMPLE_W];
      end
    end
  end

  dkong3_dc_block #(
    .DC_SHIFT  (DC_SHIFT),
    .GAIN_SHIFT(GAIN_SHIFT)
  ) u_dc_block (
    .clk_i   (I_SUBCLK),
    .rst_i   (I_RESET),
    .x_i     (x_q),
    .stb_i   (x_vld_q),
    .mute_i  (I_MUTE),
    .sample_o(O_SAMPLE),
    .stb_o   (O_SAMPLE_STB)
  );

endmodule
